// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus IO window (TX FIFO, RX holding register, status, sim halt) for the byte-serial memory bus.
// Define MEMIO_TX_STALL_EN to make a full TX FIFO stall the controller via rdy_out instead of dropping bytes.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8,
    parameter int TX_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] a_in,
    input  logic [7:0]  d_in,
    input  logic        wr_in,
    output logic [7:0]  d_out,
    output logic        rdy_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_halt
);
    logic [7:0]     mem [2**RAM_AW];
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [7:0]     rx_byte, rd_data;
    logic [2:0]     off;
    logic           io, access, tx_wr, push, pop, rx_pop, rx_load;
    logic           rd0, prev_rd0, rx_full, overflow, tx_full, full_nxt;

    assign access     = rdy_out;
    assign io         = a_in[17:16] == 2'b11;
    assign off        = a_in[2:0];
    assign rd0        = access && io && off == 3'd0 && !wr_in;
    assign tx_wr      = access && io && off == 3'd0 && wr_in;
    assign push       = tx_wr && !tx_full;
    assign pop        = tx_valid && tx_ready;
    // A held read of offset 0 pops only on its first cycle.
    assign rx_pop     = rd0 && !prev_rd0 && rx_full;
    assign rx_load    = rx_valid && rx_ready;
    assign rx_ready   = !rx_full;
    assign tx_full    = (wr_ptr[TX_AW] != rd_ptr[TX_AW]) && (wr_ptr[TX_AW-1:0] == rd_ptr[TX_AW-1:0]);
    assign tx_valid   = wr_ptr != rd_ptr;
    assign tx_data    = tx_mem[rd_ptr[TX_AW-1:0]];
    assign wr_ptr_nxt = wr_ptr + {{TX_AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{TX_AW{1'b0}}, pop};
    assign full_nxt   = (wr_ptr_nxt[TX_AW] != rd_ptr_nxt[TX_AW]) &&
                        (wr_ptr_nxt[TX_AW-1:0] == rd_ptr_nxt[TX_AW-1:0]);

    always_comb begin
        rd_data = 8'h00;
        if (!io)
            rd_data = wr_in ? d_in : mem[a_in[RAM_AW-1:0]];
        else if (off == 3'd0)
            rd_data = rx_full ? rx_byte : 8'h00;
        else if (off == 3'd4)
            rd_data = {5'b0, overflow, tx_full, rx_full};
    end

    always_ff @(posedge clk) begin
        if (access && !io && wr_in)
            mem[a_in[RAM_AW-1:0]] <= d_in;
        if (push)
            tx_mem[wr_ptr[TX_AW-1:0]] <= d_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out    <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_full  <= 1'b0;
            rx_byte  <= 8'h00;
            prev_rd0 <= 1'b0;
            overflow <= 1'b0;
            sim_halt <= 1'b0;
        end else begin
            if (access && !(io && wr_in))
                d_out <= rd_data;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            prev_rd0 <= rd0;
            sim_halt <= access && io && off == 3'd4 && wr_in;
            if (tx_wr && tx_full)
                overflow <= 1'b1;
            if (rx_load) begin
                rx_full <= 1'b1;
                rx_byte <= rx_data;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
        end
    end

`ifdef MEMIO_TX_STALL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdy_out <= 1'b1;
        else
            rdy_out <= !full_nxt;
    end
`else
    assign rdy_out = 1'b1;
    logic unused_full_nxt;
    assign unused_full_nxt = full_nxt;
`endif
endmodule
